// File: rtl/ram_bus_master.sv
// Synchronous initiator for the asynchronous nibble RAM port.
// Each accepted request runs SETUP / ACCESS / HOLD so address and data are stable while mem_cs is high.
module ram_bus_master #(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we
);

    // A WAIT_CYCLES of 0 still gives one cycle of chip select.
    localparam int unsigned WAIT_EFF = (WAIT_CYCLES == 0) ? 1 : WAIT_CYCLES;
    localparam int unsigned CNT_W    = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_e;

    state_e                state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  we_q,        we_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic                  mem_cs_q,    mem_cs_d;
    logic                  mem_we_q,    mem_we_d;
    logic                  drive_q,     drive_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  req_ready_q, req_ready_d;
    logic                  busy_q,      busy_d;

    // State and pin registers; every RAM-side pin comes straight from a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            drive_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            drive_q     <= drive_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    // Next state and next pin values; pins are computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_cs_d    = 1'b0;
        mem_we_d    = 1'b0;
        drive_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d    = SETUP;
                    we_d       = req_we;
                    wdata_d    = req_wdata;
                    mem_addr_d = req_addr;
                    mem_we_d   = req_we;
                end
            end
            SETUP: begin
                state_d  = ACCESS;
                cnt_d    = CNT_W'(WAIT_EFF - 1);
                mem_cs_d = 1'b1;
                mem_we_d = we_q;
                drive_d  = we_q;
            end
            ACCESS: begin
                // mem_we and the write drive carry on into HOLD for data hold after cs falls.
                mem_we_d = we_q;
                drive_d  = we_q;
                if (cnt_q == '0) begin
                    state_d     = HOLD;
                    rsp_valid_d = 1'b1;
                    if (!we_q) begin
                        rsp_rdata_d = mem_data;
                    end
                end else begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    mem_cs_d = 1'b1;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    assign mem_data  = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign mem_addr  = mem_addr_q;
    assign mem_cs    = mem_cs_q;
    assign mem_we    = mem_we_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign req_ready = req_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: two instances (1 and 3 wait cycles), each with a behavioural RAM,
// a request driver that pushes expectations and a negedge monitor that checks pins and responses.
module tb_ram_bus_master;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 4;
    localparam int unsigned W0 = 1;
    localparam int unsigned W1 = 3;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n   [2];
    logic          req_valid [2];
    logic          req_ready [2];
    logic          req_we    [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic          rsp_valid [2];
    logic [DW-1:0] rsp_rdata [2];
    logic          busy      [2];
    logic [AW-1:0] mem_addr  [2];
    logic          mem_cs    [2];
    logic          mem_we    [2];
    wire  [DW-1:0] md0;
    wire  [DW-1:0] md1;

    logic [DW-1:0] ram0  [4096];
    logic [DW-1:0] ram1  [4096];
    logic [DW-1:0] model [2][4096];

    exp_t exp_q [2][$];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   rsp_cnt [2];
    int   cs_run  [2];
    logic prev_cs  [2];
    logic prev_we  [2];
    logic prev_rsp [2];

    ram_bus_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .reset_n(reset_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
        .mem_addr(mem_addr[0]), .mem_data(md0), .mem_cs(mem_cs[0]), .mem_we(mem_we[0])
    );

    ram_bus_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .reset_n(reset_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
        .mem_addr(mem_addr[1]), .mem_data(md1), .mem_cs(mem_cs[1]), .mem_we(mem_we[1])
    );

    // Asynchronous RAMs: drive the bus on cs && !we, capture writes while cs && we.
    assign md0 = (mem_cs[0] && !mem_we[0]) ? ram0[mem_addr[0]] : {DW{1'bz}};
    assign md1 = (mem_cs[1] && !mem_we[1]) ? ram1[mem_addr[1]] : {DW{1'bz}};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_cs[0] && mem_we[0]) ram0[mem_addr[0]] = md0;
        if (mem_cs[1] && mem_we[1]) ram1[mem_addr[1]] = md1;
    end

    function automatic logic [DW-1:0] bus_of(input int i);
        return (i == 0) ? md0 : md1;
    endfunction

    function automatic int wait_of(input int i);
        return (i == 0) ? int'(W0) : int'(W1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: pin discipline, cs width, response timing and read data against the scoreboard.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset_n[i]) begin
                checks++;
                if (req_ready[i] == busy[i]) begin
                    errors++;
                    $display("FAIL ready_vs_busy inst%0d: ready=%b busy=%b expected ready=!busy", i, req_ready[i], busy[i]);
                end
                if (prev_cs[i] && mem_cs[i]) begin
                    checks++;
                    if (mem_we[i] != prev_we[i]) begin
                        errors++;
                        $display("FAIL we_stable inst%0d: we=%b expected %b while cs high", i, mem_we[i], prev_we[i]);
                    end
                end
                if (mem_cs[i] && exp_q[i].size() > 0) begin
                    checks++;
                    if (mem_addr[i] != exp_q[i][0].addr || mem_we[i] != exp_q[i][0].we) begin
                        errors++;
                        $display("FAIL cs_addr inst%0d: addr=%0h we=%b expected addr=%0h we=%b", i,
                                 mem_addr[i], mem_we[i], exp_q[i][0].addr, exp_q[i][0].we);
                    end
                    if (mem_we[i]) begin
                        checks++;
                        if (bus_of(i) !== exp_q[i][0].data) begin
                            errors++;
                            $display("FAIL wr_bus inst%0d: data=%0h expected %0h", i, bus_of(i), exp_q[i][0].data);
                        end
                    end
                end
                if (mem_cs[i]) begin
                    cs_run[i]++;
                end else if (prev_cs[i]) begin
                    checks++;
                    if (cs_run[i] != wait_of(i)) begin
                        errors++;
                        $display("FAIL cs_width inst%0d: cs high %0d cycles expected %0d", i, cs_run[i], wait_of(i));
                    end
                    cs_run[i] = 0;
                end
                if (rsp_valid[i]) begin
                    checks++;
                    if (prev_rsp[i] || exp_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL rsp_strobe inst%0d: extra rsp_valid (prev=%b pending=%0d) expected single strobe",
                                 i, prev_rsp[i], exp_q[i].size());
                    end else begin
                        exp_t e;
                        e = exp_q[i].pop_front();
                        rsp_cnt[i]++;
                        checks++;
                        if (cyc - e.acc != 1 + wait_of(i)) begin
                            errors++;
                            $display("FAIL rsp_latency inst%0d: %0d edges after acceptance expected %0d",
                                     i, cyc - e.acc, 1 + wait_of(i));
                        end
                        if (!e.we) begin
                            checks++;
                            if (rsp_rdata[i] !== e.data) begin
                                errors++;
                                $display("FAIL rd_data inst%0d addr %0h: got %0h expected %0h", i, e.addr, rsp_rdata[i], e.data);
                            end
                        end
                    end
                end
            end
            prev_cs[i]  = mem_cs[i];
            prev_we[i]  = mem_we[i];
            prev_rsp[i] = rsp_valid[i];
        end
    end

    // Called at a negedge; holds req_valid until accepted and returns at the negedge after acceptance.
    task automatic issue(input int i, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        exp_t e;
        int   guard;
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wd;
        guard = 0;
        while (!req_ready[i] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready[i]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout inst%0d: ready=0 expected 1 within 200 cycles", i);
            req_valid[i] = 1'b0;
            return;
        end
        e.we   = we;
        e.addr = addr;
        e.acc  = cyc + 1;
        if (we) begin
            e.data = wd;
            model[i][addr] = wd;
        end else begin
            e.data = model[i][addr];
        end
        exp_q[i].push_back(e);
        @(negedge clk);
        req_valid[i] = 1'b0;
        req_we[i]    = ~we;
        req_addr[i]  = ~addr;
        req_wdata[i] = ~wd;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        chk("drain_pending", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int base;
        for (int a = 0; a < 4096; a++) begin
            ram0[a] = '0;
            ram1[a] = '0;
            model[0][a] = '0;
            model[1][a] = '0;
        end
        for (int i = 0; i < 2; i++) begin
            reset_n[i]   = 1'b0;
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            rsp_cnt[i]   = 0;
            cs_run[i]    = 0;
            prev_cs[i]   = 1'b0;
            prev_we[i]   = 1'b0;
            prev_rsp[i]  = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Reset values.
        for (int i = 0; i < 2; i++) begin
            chk("rst_cs",    32'(mem_cs[i]),    32'd0);
            chk("rst_we",    32'(mem_we[i]),    32'd0);
            chk("rst_rsp",   32'(rsp_valid[i]), 32'd0);
            chk("rst_rdata", 32'(rsp_rdata[i]), 32'd0);
            chk("rst_busy",  32'(busy[i]),      32'd0);
            chk("rst_addr",  32'(mem_addr[i]),  32'd0);
        end
        reset_n[0] = 1'b1;
        reset_n[1] = 1'b1;
        @(negedge clk);
        chk("ready_after_rst0", 32'(req_ready[0]), 32'd1);
        chk("ready_after_rst1", 32'(req_ready[1]), 32'd1);

        // Write then read with one wait cycle.
        issue(0, 1'b1, 12'h123, 4'hA);
        issue(0, 1'b0, 12'h123, 4'h0);
        drain();

        // Three wait cycles.
        issue(1, 1'b1, 12'h0FF, 4'h5);
        issue(1, 1'b0, 12'h0FF, 4'h0);
        drain();

        // Back-to-back with req_valid held high, including the top address.
        base = rsp_cnt[0];
        issue(0, 1'b1, 12'h000, 4'h1);
        issue(0, 1'b1, 12'h001, 4'h2);
        issue(0, 1'b1, 12'hFFF, 4'h3);
        issue(0, 1'b0, 12'h000, 4'h0);
        issue(0, 1'b0, 12'h001, 4'h0);
        issue(0, 1'b0, 12'hFFF, 4'h0);
        drain();
        chk("b2b_rsp_count", 32'(rsp_cnt[0] - base), 32'd6);

        // Reset during a write ACCESS; the aborted request gets no response.
        issue(0, 1'b1, 12'h200, 4'h7);
        @(negedge clk);
        chk("abort_cs_before", 32'(mem_cs[0]), 32'd1);
        #1 reset_n[0] = 1'b0;
        #1;
        chk("abort_cs",    32'(mem_cs[0]),    32'd0);
        chk("abort_we",    32'(mem_we[0]),    32'd0);
        chk("abort_rsp",   32'(rsp_valid[0]), 32'd0);
        chk("abort_busy",  32'(busy[0]),      32'd0);
        chk("abort_addr",  32'(mem_addr[0]),  32'd0);
        exp_q[0].delete();
        prev_cs[0]  = 1'b0;
        prev_rsp[0] = 1'b0;
        cs_run[0]   = 0;
        base = rsp_cnt[0];
        @(negedge clk);
        reset_n[0] = 1'b1;
        @(negedge clk);
        chk("abort_no_rsp", 32'(rsp_cnt[0] - base), 32'd0);
        issue(0, 1'b0, 12'h123, 4'h0);
        drain();
        chk("post_abort_rsp", 32'(rsp_cnt[0] - base), 32'd1);

        // Random traffic over a small address window plus the top address.
        for (int n = 0; n < 1000; n++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 9) == 0) ? 12'hFFF : AW'($urandom_range(0, 15));
            issue(0, 1'($urandom_range(0, 1)), a, DW'($urandom));
        end
        for (int n = 0; n < 100; n++) begin
            issue(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
